// File: rtl/pipe_pkg.sv
// Shared state encoding for elastic pipeline stages.
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Encoding doubles as the entry count, so occupancy is the state itself.
  function automatic logic [1:0] entries(input logic [1:0] st);
    return (st == ST_FULL) ? 2'd2 : (st == ST_HALF) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/register.sv
// Plain load/clear register; clear wins over load, async active-low reset to zero.
module register #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage with freeze, flush and a stall counter.
// in_ready decodes registered state only, so out_ready never reaches the upstream side.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             freeze,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [1:0]       state, next_state;
  logic             in_xfer, out_xfer;
  logic             main_ld, skid_ld;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_ready  = rst & (state != ST_FULL) & ~freeze & ~flush;
  assign out_valid = (state != ST_EMPTY) & ~freeze;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign occupancy = entries(state);

  always_comb begin
    next_state = state;
    main_ld    = 1'b0;
    skid_ld    = 1'b0;
    main_d     = in_data;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) begin
          next_state = ST_HALF;
          main_ld    = 1'b1;
        end
        ST_HALF: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (in_xfer) begin
            next_state = ST_FULL;
            skid_ld    = 1'b1;
          end else if (out_xfer) begin
            next_state = ST_EMPTY;
          end
        end
        ST_FULL: if (out_xfer) begin
          next_state = ST_HALF;
          main_ld    = 1'b1;
          main_d     = skid_q;
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= next_state;
  end

  // Counts every presented-but-refused cycle; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  register #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .rst(rst), .ld(main_ld), .clr(flush), .d(main_d), .q(out_data)
  );

  register #(.WIDTH(WIDTH)) u_skid (
    .clk(clk), .rst(rst), .ld(skid_ld), .clr(flush), .d(in_data), .q(skid_q)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with CNT_W=4 covers counter saturation.
module tb_pipe_stage_reg;
  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, freeze, flush;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        in_ready4, out_valid4;
  logic [63:0] out_data4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;
  int          n_cmp = 0;
  int          n_err = 0;

  pipe_stage_reg #(.WIDTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .freeze(freeze),
    .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .freeze(freeze),
    .flush(flush), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 64'hAAAA_AAAA_AAAA_AAAA;
    out_ready = 1'b1; freeze = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    cyc(); cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL rst_release_pre_edge got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hAAAA_AAAA_AAAA_AAAA || occupancy !== 2'd1) begin
      n_err++; $display("FAIL rst_first_edge got v=%b d=%h occ=%0d want v=1 d=aaaaaaaaaaaaaaaa occ=1", out_valid, out_data, occupancy); end
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_drain got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
  endtask

  task automatic test_stream();
    logic [63:0] d;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 64'h1000_0000_0000_0000 + 64'(i);
      in_data = d;
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== d || occupancy !== 2'd1) begin
        n_err++; $display("FAIL stream_%0d got v=%b d=%h occ=%0d want v=1 d=%h occ=1", i, out_valid, out_data, occupancy, d); end
    end
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain got occ=%0d want 0", occupancy); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hD0D0_0000_0000_0000;
    cyc();
    in_data = 64'hD1D1_0000_0000_0001;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL bp_stall1 got %0d want 1", stall_cnt); end
    cyc();
    n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL bp_stall2 got %0d want 2", stall_cnt); end
    cyc();
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL bp_stall3 got %0d want 3", stall_cnt); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hD0D0_0000_0000_0000) begin n_err++; $display("FAIL bp_first got v=%b d=%h want v=1 d=d0d0000000000000", out_valid, out_data); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hD1D1_0000_0000_0001 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL bp_second got v=%b d=%h occ=%0d want v=1 d=d1d1000000000001 occ=1", out_valid, out_data, occupancy); end
    cyc();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || stall_cnt !== 16'd3) begin
      n_err++; $display("FAIL bp_drain got occ=%0d v=%b stall=%0d want occ=0 v=0 stall=3", occupancy, out_valid, stall_cnt); end
  endtask

  task automatic test_freeze();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE0;
    cyc();
    in_data = 64'hE1;
    cyc();
    in_valid = 1'b0; freeze = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd2 || stall_cnt !== 16'd4) begin
        n_err++; $display("FAIL freeze_%0d got v=%b rdy=%b occ=%0d stall=%0d want v=0 rdy=0 occ=2 stall=4", i, out_valid, in_ready, occupancy, stall_cnt); end
      cyc();
    end
    freeze = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hE0) begin n_err++; $display("FAIL freeze_release got v=%b d=%h want v=1 d=e0", out_valid, out_data); end
    cyc();
    n_cmp++; if (out_data !== 64'hE1 || occupancy !== 2'd1) begin n_err++; $display("FAIL freeze_second got d=%h occ=%0d want d=e1 occ=1", out_data, occupancy); end
    cyc();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL freeze_drain got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hF0;
    cyc();
    in_data = 64'hF1;
    cyc();
    flush = 1'b1; freeze = 1'b1; in_data = 64'hF2;
    cyc();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_after got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", out_valid, out_data, in_ready); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL flush_stall got %0d want 5", stall_cnt); end
    cyc();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_capture got occ=%0d v=%b want 0 0", occupancy, out_valid); end
  endtask

  task automatic test_saturate();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    n_cmp++; if (stall_cnt4 !== 4'd0) begin n_err++; $display("FAIL sat_reset got %0d want 0", stall_cnt4); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 5 || k == 15 || k == 20) begin
        n_cmp++; if (stall_cnt4 !== ((k > 15) ? 4'd15 : 4'(k))) begin
          n_err++; $display("FAIL sat_k%0d got %0d want %0d", k, stall_cnt4, (k > 15) ? 15 : k); end
      end
    end
    n_cmp++; if (stall_cnt !== 16'd20) begin n_err++; $display("FAIL sat_wide got %0d want 20", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 64'h66;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL mid_pre got occ=%0d want 2", occupancy); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL mid_async got occ=%0d v=%b d=%h rdy=%b stall=%0d want 0 0 0 0 0", occupancy, out_valid, out_data, in_ready, stall_cnt); end
    cyc();
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h1234; out_ready = 1'b1;
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h1234 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL mid_after got v=%b d=%h occ=%0d want v=1 d=1234 occ=1", out_valid, out_data, occupancy); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_flush();
    test_saturate();
    test_reset_mid();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits (e.g. {pc, instruction}).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream holds valid payload.
REQ-006 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  stage presents valid payload.
REQ-009 SHALL have port out_ready  input  1  downstream accepts payload this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  payload presented downstream.
REQ-011 SHALL have port freeze  input  1  hold all state; no transfer on either side.
REQ-012 SHALL have port flush  input  1  discard all held entries.
REQ-013 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-015 SHALL hold up to two entries: a main register driving out_data and a skid register.
REQ-016 SHALL implement states EMPTY (0 entries), HALF (main only) and FULL (main + skid); occupancy SHALL equal 0, 1 and 2 respectively.
REQ-017 SHALL drive in_ready = (state != FULL) & ~freeze & ~flush, decoded from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY) & ~freeze; out_data SHALL be the main register contents.
REQ-019 SHALL define input transfer as in_valid & in_ready, and output transfer as out_valid & out_ready.
REQ-020 SHALL apply EMPTY transitions: input transfer loads main and moves to HALF; otherwise stay in EMPTY.
REQ-021 SHALL apply HALF transitions: input only moves to FULL with data in skid; output only moves to EMPTY; both load main with in_data and stay in HALF; neither stays in HALF.
REQ-022 SHALL apply FULL transitions: output transfer copies skid to main and moves to HALF; otherwise stay in FULL. No input transfer occurs in FULL.
REQ-023 SHALL give a latency of 1 cycle from input transfer to out_valid when the stage was EMPTY, or when in HALF with a simultaneous output transfer.
REQ-024 SHALL sustain a throughput of one transfer per cycle while out_ready=1 and freeze=0.
REQ-025 SHALL, with freeze=1 and flush=0, leave state, entries and stall_cnt unchanged; no transfer occurs.
REQ-026 SHALL, with flush=1, set state to EMPTY and both entries to 0 at the next edge, with priority over freeze and any handshake; in_data is not captured.
REQ-027 SHALL increment stall_cnt on each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1; flush SHALL NOT clear it.
REQ-028 SHALL keep payload bits unchanged through the stage: no arithmetic and no reordering, so the stage is strictly FIFO.

Reset
REQ-029 SHALL, on rst=0 and without waiting for clk, force state=EMPTY, both entries=0 and stall_cnt=0, giving out_valid=0, out_data=0, occupancy=0 and in_ready=0 while reset is asserted.
REQ-030 SHALL, on reset assertion mid-operation, drop held entries with no partial transfer; after rst deassertion, the first edge behaves as from EMPTY.

Structure
REQ-031 SHALL place the state encoding (EMPTY/HALF/FULL, 2-bit) in shared package pipe_pkg.
REQ-032 SHALL build each entry from the existing Register module (WIDTH, ld, clr), giving two instances; the control FSM and stall counter are local.

Verification
REQ-033 SHALL cover: reset with in_data=0xAAAA..., in_valid=1 -> out_valid=0, out_data=0, occupancy=0 until the first edge after rst=1.
REQ-034 SHALL cover: stream D0..D7 with out_ready=1 -> out_data shows D0..D7 on consecutive cycles one cycle late, occupancy stays 1, stall_cnt=0.
REQ-035 SHALL cover: send D0,D1 with out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments each cycle; on out_ready=1, D0 then D1 appear with no loss or duplication.
REQ-036 SHALL cover: freeze=1 for 5 cycles while FULL with out_ready=1 -> out_valid=0, in_ready=0, contents and stall_cnt unchanged; after release, D0 emerges first.
REQ-037 SHALL cover: flush=1 together with freeze=1, in_valid=1 and state FULL -> next cycle occupancy=0, out_valid=0, in_data dropped.
REQ-038 SHALL cover: CNT_W=4 with out_ready held 0 for 20 cycles -> stall_cnt saturates at 15.
